// File: rtl/div_prog_if.sv
// Config handshake and divided-clock outputs of the programmable clock divider.
interface div_prog_if #(
    parameter int unsigned CNT_W = 16
) ();
    logic             en;
    logic             cfg_valid;
    logic             cfg_ready;
    logic [CNT_W-1:0] div_val;
    logic [CNT_W-1:0] high_val;
    logic             clk_div;
    logic             tick;
    logic             cfg_err;

    modport master (
        output en, cfg_valid, div_val, high_val,
        input  cfg_ready, clk_div, tick, cfg_err
    );

    modport slave (
        input  en, cfg_valid, div_val, high_val,
        output cfg_ready, clk_div, tick, cfg_err
    );
endinterface

// File: rtl/div_prog.sv
// Programmable clock divider with duty-cycle control; new ratios are staged
// and applied only at a period boundary (or while stopped), so the output never glitches.
module div_prog #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned DEF_DIV = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    div_prog_if.slave   bus
);
    localparam logic [CNT_W-1:0] DEF_DIV_W  = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] DEF_HIGH_W = CNT_W'(DEF_DIV >> 1);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO        = CNT_W'(2);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] high_act;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] pend_high;
    logic             pend_vld;

    logic             last_c;
    logic             apply_c;
    logic             xfer_c;
    logic             bad_c;

    always_comb begin
        last_c  = (cnt == div_act - ONE);
        apply_c = pend_vld & (~bus.en | last_c);
        xfer_c  = bus.cfg_valid & ~pend_vld;
        bad_c   = (bus.div_val < TWO) |
                  ((bus.high_val != '0) & (bus.high_val >= bus.div_val));
    end

    assign bus.cfg_ready = ~pend_vld;

    // Rst_n is active-high despite its name; it clears everything immediately.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt         <= '0;
            div_act     <= DEF_DIV_W;
            high_act    <= DEF_HIGH_W;
            pend_div    <= '0;
            pend_high   <= '0;
            pend_vld    <= 1'b0;
            bus.clk_div <= 1'b0;
            bus.tick    <= 1'b0;
            bus.cfg_err <= 1'b0;
        end else begin
            cnt         <= (bus.en && !last_c) ? cnt + ONE : '0;
            bus.clk_div <= bus.en & (cnt < high_act);
            bus.tick    <= bus.en & last_c;
            bus.cfg_err <= 1'b0;

            // A pending config blocks new transfers, so apply and accept are exclusive.
            if (apply_c) begin
                div_act  <= pend_div;
                high_act <= pend_high;
                pend_vld <= 1'b0;
            end else if (xfer_c) begin
                if (bad_c) begin
                    bus.cfg_err <= 1'b1;
                end else begin
                    pend_div  <= bus.div_val;
                    pend_high <= (bus.high_val == '0) ? (bus.div_val >> 1) : bus.high_val;
                    pend_vld  <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_div_prog.sv
// Directed scenarios plus random stimulus for div_prog, checked every cycle
// against a period-position reference model.
module tb_div_prog;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned DEF_DIV = 4;

    logic clk;
    logic rst_n;

    div_prog_if #(.CNT_W(CNT_W)) bus ();

    div_prog #(.CNT_W(CNT_W), .DEF_DIV(DEF_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: position inside the current period and the configs.
    int m_pos, m_div, m_high;
    int p_div, p_high;
    bit p_vld;
    bit e_clk_div, e_tick, e_err;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_div = DEF_DIV; m_high = DEF_DIV / 2;
        p_vld = 0; p_div = 0; p_high = 0;
        e_clk_div = 0; e_tick = 0; e_err = 0;
    endtask

    task automatic model_step();
        int  d, h, nxt;
        bit  at_end, en;
        en     = bus.en;
        at_end = (m_pos == m_div - 1);
        e_clk_div = en && (m_pos < m_high);
        e_tick    = en && at_end;
        e_err     = 0;
        nxt = en ? (m_pos + 1) % m_div : 0;
        if (p_vld && (!en || at_end)) begin
            m_div = p_div; m_high = p_high; p_vld = 0;
        end else if (bus.cfg_valid && !p_vld) begin
            d = int'(bus.div_val);
            h = int'(bus.high_val);
            if (d < 2 || (h != 0 && h >= d)) begin
                e_err = 1;
            end else begin
                p_div = d; p_high = (h == 0) ? d / 2 : h; p_vld = 1;
            end
        end
        m_pos = nxt;
    endtask

    task automatic compare_outputs();
        check("clk_div",   32'(bus.clk_div),   32'(e_clk_div));
        check("tick",      32'(bus.tick),      32'(e_tick));
        check("cfg_err",   32'(bus.cfg_err),   32'(e_err));
        check("cfg_ready", 32'(bus.cfg_ready), 32'(!p_vld));
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_reset();
        else       model_step();
        #1;
        compare_outputs();
    endtask

    task automatic drive(input bit en, input bit v, input int d, input int h);
        bus.en        = en;
        bus.cfg_valid = v;
        bus.div_val   = CNT_W'(d);
        bus.high_val  = CNT_W'(h);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_pos(input int p);
        int n = 0;
        while (m_pos != p && n < 64) begin
            cycle();
            n++;
        end
        check("wait_pos", 32'(m_pos), 32'(p));
    endtask

    // Asynchronous reset pulse between edges; outputs must be forced low at once.
    task automatic pulse_reset(input int hold);
        #2 rst_n = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        run(hold);
        #3 rst_n = 1'b0;
    endtask

    initial begin
        rst_n = 1'b1;
        drive(0, 0, 0, 0);
        model_reset();
        #1;
        compare_outputs();
        run(2);
        #3 rst_n = 1'b0;

        // Default ratio 4, high 2
        drive(1, 0, 0, 0);
        run(12);

        // Stage 5/50% mid-period at cnt=1
        wait_pos(1);
        drive(1, 1, 5, 0);
        cycle();
        check("ready_drop", 32'(bus.cfg_ready), 32'd0);
        drive(1, 0, 0, 0);
        run(16);

        // Two rejected configs
        drive(1, 1, 1, 0);
        cycle();
        drive(1, 1, 6, 6);
        cycle();
        check("err_second", 32'(bus.cfg_err), 32'd1);
        drive(1, 0, 0, 0);
        run(10);

        // Apply while stopped, then run 7/3
        drive(0, 1, 7, 3);
        cycle();
        drive(0, 0, 0, 0);
        cycle();
        drive(1, 0, 0, 0);
        run(22);

        // Stop at cnt=2 for three cycles
        wait_pos(2);
        drive(0, 0, 0, 0);
        run(3);
        drive(1, 0, 0, 0);
        run(16);

        // Reset with a pending ratio 9
        drive(1, 1, 9, 0);
        cycle();
        drive(1, 0, 0, 0);
        pulse_reset(2);
        run(12);

        // Minimum ratio 2, high 1
        drive(1, 1, 2, 1);
        cycle();
        drive(1, 0, 0, 0);
        run(12);

        // Random traffic with one asynchronous reset in the middle
        for (int i = 0; i < 2000; i++) begin
            drive(($urandom_range(0, 15) != 0),
                  ($urandom_range(0, 5) == 0),
                  int'($urandom_range(0, 12)),
                  int'($urandom_range(0, 13)));
            if (i == 1000) pulse_reset(3);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
